zx_key_decoder: RTL and testbench

//  Decoder side of the ZX keyboard-matrix stimulus interface. Watches the eight

---
 rtl/zx_key_decoder.sv | 202 ++++++++++++++++++++
 tb/tb_zx_key_decoder.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/zx_key_decoder.sv
// zx_key_decoder: watches the eight active-low ZX half-row buses, debounces
// them, encodes each distinct keypress into a 16-bit sequence code
// {row, mod, cols} and queues the codes in a small first-word-fall-through FIFO.
module zx_key_decoder #(
    parameter int CLK_FREQ       = 27000000,
    parameter int DEBOUNCE_TICKS = CLK_FREQ / 1000 * 5,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  key_0,
    input  logic [4:0]  key_1,
    input  logic [4:0]  key_2,
    input  logic [4:0]  key_3,
    input  logic [4:0]  key_4,
    input  logic [4:0]  key_5,
    input  logic [4:0]  key_6,
    input  logic [4:0]  key_7,
    output logic [15:0] code_out,
    output logic        code_valid,
    input  logic        code_ready,
    output logic        ghost,
    output logic        overflow,
    output logic        busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(DEBOUNCE_TICKS);
    localparam logic [39:0] ALL_UP = '1;

    typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_REL} state_t;

    logic [39:0]   key_bus;
    logic [39:0]   sync1_reg, sync2_reg, snap;
    logic [39:0]   cand_reg, cand_next;
    logic [TW-1:0] timer_reg, timer_next;
    state_t        state_reg, state_next;
    logic          timer_done, snap_up;

    assign key_bus = {key_7, key_6, key_5, key_4, key_3, key_2, key_1, key_0};
    assign snap    = sync2_reg;
    assign snap_up = (snap == ALL_UP);
    assign timer_done = (timer_reg == TW'(DEBOUNCE_TICKS - 1));

    // Two-stage synchroniser for the asynchronous key buses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= ALL_UP;
            sync2_reg <= ALL_UP;
        end else begin
            sync1_reg <= key_bus;
            sync2_reg <= sync1_reg;
        end
    end

    // ---------------- decode of the debounced candidate ----------------
    logic        cs, ss;
    logic [39:0] masked;
    logic [7:0]  row_hit;
    logic [4:0]  row_cols [8];
    logic [3:0]  hit_count;
    logic [2:0]  hit_idx;
    logic [15:0] decoded_code;

    assign cs = ~cand_reg[0];
    assign ss = ~cand_reg[36];
    // Shift keys are removed so they never count as a row of their own
    assign masked = cand_reg | {3'b000, ss, 35'd0, cs};

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rows
            assign row_cols[gi] = masked[gi*5 +: 5];
            assign row_hit[gi]  = ~&masked[gi*5 +: 5];
        end
    endgenerate

    // Count non-shift rows and pick the (single) active one
    always_comb begin
        hit_count = '0;
        hit_idx   = '0;
        for (int i = 0; i < 8; i++) begin
            if (row_hit[i]) begin
                hit_count = hit_count + 4'd1;
                hit_idx   = 3'(i);
            end
        end
    end

    // Build the sequence code; shift-only presses map to fixed codes
    always_comb begin
        decoded_code = '0;
        if (hit_count == 4'd1)
            decoded_code = {5'd0, hit_idx, 1'b0, cs, ss, row_cols[hit_idx]};
        else if (cs && ss)
            decoded_code = 16'h003E;
        else if (cs)
            decoded_code = 16'h001E;
        else
            decoded_code = 16'h071D;
    end

    // ---------------- debounce FSM ----------------
    logic push_req, ghost_next;

    // FSM state, candidate pattern and stability timer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cand_reg  <= ALL_UP;
            timer_reg <= '0;
        end else begin
            state_reg <= state_next;
            cand_reg  <= cand_next;
            timer_reg <= timer_next;
        end
    end

    // Next-state logic; a code is issued once per full press/release cycle
    always_comb begin
        state_next = state_reg;
        cand_next  = cand_reg;
        timer_next = timer_reg;
        push_req   = 1'b0;
        ghost_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!snap_up) begin
                    state_next = DEB_PRESS;
                    cand_next  = snap;
                    timer_next = '0;
                end
            end
            DEB_PRESS: begin
                if (snap_up) begin
                    state_next = IDLE;
                end else if (snap != cand_reg) begin
                    cand_next  = snap;
                    timer_next = '0;
                end else if (timer_done) begin
                    state_next = HELD;
                    if (hit_count > 4'd1) ghost_next = 1'b1;
                    else                  push_req   = 1'b1;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            HELD: begin
                if (snap_up) begin
                    state_next = DEB_REL;
                    timer_next = '0;
                end
            end
            DEB_REL: begin
                if (!snap_up)        state_next = HELD;
                else if (timer_done) state_next = IDLE;
                else                 timer_next = timer_reg + 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- code FIFO ----------------
    logic [15:0]   mem_reg [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          ghost_reg, overflow_reg;
    logic          full, do_pop, do_push;

    assign full    = (count_reg == CW'(FIFO_DEPTH));
    assign do_pop  = code_valid && code_ready;
    assign do_push = push_req && (!full || do_pop);

    // FIFO storage, pointers, occupancy and the status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_reg[i] <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            ghost_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            ghost_reg <= ghost_next;
            if (push_req && full && !do_pop) overflow_reg <= 1'b1;
            if (do_push) begin
                mem_reg[wr_ptr_reg] <= decoded_code;
                wr_ptr_reg          <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
            else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
        end
    end

    assign code_valid = (count_reg != '0);
    assign code_out   = code_valid ? mem_reg[rd_ptr_reg] : 16'h0000;
    assign ghost      = ghost_reg;
    assign overflow   = overflow_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_zx_key_decoder.sv
// Testbench for zx_key_decoder: directed key patterns, expected codes pushed
// into a scoreboard queue and checked by an independent output monitor.
module tb_zx_key_decoder;
    logic        clk = 1'b0;
    logic        reset;
    logic [39:0] keys;
    logic [15:0] code_out;
    logic        code_valid, code_ready, ghost, overflow, busy;

    int total = 0;
    int bad = 0;
    int ghost_cnt = 0;
    logic [15:0] exp_q [$];

    localparam logic [39:0] UP = '1;

    zx_key_decoder #(.CLK_FREQ(27000000), .DEBOUNCE_TICKS(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .key_0(keys[4:0]),   .key_1(keys[9:5]),   .key_2(keys[14:10]),
        .key_3(keys[19:15]), .key_4(keys[24:20]), .key_5(keys[29:25]),
        .key_6(keys[34:30]), .key_7(keys[39:35]),
        .code_out(code_out), .code_valid(code_valid), .code_ready(code_ready),
        .ghost(ghost), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%h required=%h", name, act, req);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    // Pattern with one half-row driven to v, all other rows released
    function automatic logic [39:0] row(input int r, input logic [4:0] v);
        logic [39:0] p;
        p = UP;
        p[r*5 +: 5] = v;
        return p;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold a pattern then release long enough to finish release debounce
    task automatic press(input logic [39:0] pat, input int hold);
        keys = pat;
        tick(hold);
        keys = UP;
        tick(12);
    endtask

    // Monitor: pops the scoreboard on every accepted code
    always @(negedge clk) begin
        if (!reset) begin
            if (ghost) ghost_cnt++;
            if (code_valid && code_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_code got=%h required=none", code_out);
                end else begin
                    check("code", {16'd0, code_out}, {16'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        int g0;
        keys = UP;
        code_ready = 1'b1;
        reset = 1'b1;
        tick(3);
        check("rst_code_valid", {31'd0, code_valid}, 0);
        check("rst_code_out", {16'd0, code_out}, 0);
        check("rst_flags", {29'd0, ghost, overflow, busy}, 0);
        reset = 1'b0;
        tick(2);

        // 1: single key, latency of DEBOUNCE_TICKS+3 edges, no repeat code
        exp_q.push_back(16'h071E);
        keys = row(7, 5'b11110);
        tick(6);
        check("lat_before", {31'd0, code_valid}, 0);
        tick(1);
        check("lat_at7", {31'd0, code_valid}, 1);
        tick(13);
        keys = UP;
        tick(15);

        // 2: caps shift combinations
        exp_q.push_back(16'h015E);
        press(row(0, 5'b11110) & row(1, 5'b11110), 10);
        exp_q.push_back(16'h005D);
        press(row(0, 5'b11100), 10);

        // 3: symbol shift combinations
        exp_q.push_back(16'h023B);
        press(row(7, 5'b11101) & row(2, 5'b11011), 10);
        exp_q.push_back(16'h071D);
        press(row(7, 5'b11101), 10);

        // 4: bouncing press, then a short release glitch while held
        for (int i = 0; i < 3; i++) begin
            keys = row(3, 5'b11110); tick(2);
            keys = UP;               tick(2);
        end
        exp_q.push_back(16'h031E);
        keys = row(3, 5'b11110);
        tick(12);
        keys = UP;               tick(3);
        keys = row(3, 5'b11110); tick(10);
        keys = UP;               tick(12);

        // 5: two non-shift rows -> ghost, no code
        g0 = ghost_cnt;
        press(row(1, 5'b11110) & row(2, 5'b11110), 10);
        check("ghost_pulses", ghost_cnt - g0, 1);
        check("ghost_no_code", {31'd0, code_valid}, 0);

        // 6: overflow with consumer stalled, ordering preserved
        code_ready = 1'b0;
        exp_q.push_back(16'h041E); press(row(4, 5'b11110), 10);
        exp_q.push_back(16'h051D); press(row(5, 5'b11101), 10);
        exp_q.push_back(16'h061B); press(row(6, 5'b11011), 10);
        exp_q.push_back(16'h0017); press(row(0, 5'b10111), 10);
        check("ovf_before", {31'd0, overflow}, 0);
        press(row(1, 5'b01111), 10);
        check("ovf_after", {31'd0, overflow}, 1);
        check("full_head", {16'd0, code_out}, 32'h041E);
        code_ready = 1'b1;
        tick(8);
        check("drained", {31'd0, code_valid}, 0);
        check("ovf_sticky", {31'd0, overflow}, 1);

        // Reset in the middle of a debounce aborts everything
        code_ready = 1'b0;
        exp_q.push_back(16'h021E);
        press(row(2, 5'b11110), 10);
        check("queued", {31'd0, code_valid}, 1);
        keys = row(3, 5'b01111);
        tick(4);
        check("mid_busy", {31'd0, busy}, 1);
        reset = 1'b1;
        keys = UP;
        #1;
        check("mr_code_valid", {31'd0, code_valid}, 0);
        check("mr_flags", {29'd0, ghost, overflow, busy}, 0);
        exp_q.delete();
        tick(2);
        reset = 1'b0;
        code_ready = 1'b1;
        tick(15);
        check("post_rst_idle", {30'd0, code_valid, busy}, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
